piece_queue: RTL and testbench
==============================

Name: piece_queue

Overview:
- Sits directly downstream of the 3-bit Tetris randomizer and upstream of the game-control FSM.
- Turns the raw random stream into legal tetromino IDs 0..6 using a 7-bag rule: every piece appears exactly once per bag of 7.
- Buffers the IDs in a small preview FIFO.
- Hands the head piece to the game FSM on a request/valid handshake and exposes the next piece for the preview display.

Parameters:
DEPTH, 3, preview FIFO entries (2..7).
MAX_REJECT, 15, consecutive rejected samples before the deterministic fallback pick.

Ports:
clk  input  1  system clock; block uses the rising edge.
restart  input  1  reset, synchronous, active-high (already decided).
rand_in  input  3  randomizer output; updates on the falling edge, so it is stable at every rising edge.
piece_req  input  1  game FSM pops the head piece.
piece_id  output  3  head piece ID, 0..6; 7 never driven.
piece_valid  output  1  FIFO non-empty.
preview_id  output  3  second FIFO entry; 0 when count<2.
queue_ready  output  1  sticky; set the first cycle the FIFO reaches DEPTH after restart.

Behaviour:
- Reset, on a rising edge with restart=1: FIFO entries=0, count=0, rd/wr pointers=0, bag mask=0, reject counter=0, state=FILL, piece_id=0, piece_valid=0, preview_id=0, queue_ready=0. Reset overrides everything, including mid-pop and mid-fill.
- Candidate generation:
  - Runs every cycle in which count<DEPTH, or count=DEPTH with a pop in the same cycle.
  - rand_in=0 is rejected.
  - For v=1..7, the candidate is c=v-1. It is rejected if bag mask bit c=1; otherwise it is accepted.
  - Each rejection increments the reject counter.
  - When the reject counter reaches MAX_REJECT, that cycle ignores rand_in and accepts the lowest-index piece with mask bit 0. The counter then clears.
  - Every accept clears the reject counter.
- On accept:
  - Piece written at wr pointer; wr pointer wraps modulo DEPTH; mask bit c set.
  - If the mask becomes 7'b1111111, it is cleared to 0 in the same cycle, starting a new bag. The piece just written belongs to the completed bag.
- Pop:
  - A pop occurs when piece_req=1 and piece_valid=1 on a rising edge. The rd pointer advances modulo DEPTH.
  - piece_req while piece_valid=0 is ignored; no state changes.
- Simultaneous push and pop: both take effect and count is unchanged. With count=DEPTH, a push is allowed only because of the same-cycle pop.
- Outputs are registered and reflect post-edge state, so pop-to-new-piece_id latency is 1 cycle. piece_valid = (count!=0). preview_id = entry at rd+1 (mod DEPTH) when count>=2.
- State machine:
  - FILL → RUN when count reaches DEPTH; queue_ready is set at that point and stays high until restart.
  - RUN has no transition back to FILL. Refilling after pops continues in RUN.
  - Pops are legal in FILL.
- Widths:
  - count: 3 bits.
  - Reject counter: 4 bits, saturates at MAX_REJECT.
  - Pointers: clog2(DEPTH) bits, wrapped explicitly (not by natural overflow) for non-power-of-2 DEPTH.

Test Plan:
1. Restart 1 cycle, then rand_in sequence 3,5,1 → after 3 rising edges: FIFO = {2,4,0}, piece_id=2, preview_id=4, piece_valid=1, queue_ready=1, count=3.
2. Bag rule: pop continuously and drive rand_in 1..7 in any order with duplicates → each group of 7 popped IDs is a permutation of 0..6. A duplicate (e.g. rand_in=3 twice) is not enqueued the second time.
3. Starvation: hold rand_in=0 for MAX_REJECT=15 cycles with mask=0 → on the 15th cycle piece 0 is enqueued and the reject counter returns to 0. With mask=7'b0000101, the fallback enqueues 1.
4. Full plus pop: count=3, piece_req=1, rand_in=7 (6 unused) → same edge pops the head and enqueues 6; count stays 3; piece_id becomes the old preview_id.
5. Underflow: after restart with rand_in held at 0, pulse piece_req before any accept → piece_valid stays 0, pointers unchanged, piece_id=0.
6. Reset mid-operation: assert restart while count=2, mask=7'b0110000 and piece_req=1 → next edge: all outputs 0, mask 0, queue_ready 0; the fill restarts cleanly.

Source files
------------

// File: rtl/piece_queue.sv
// 7-bag tetromino picker feeding a small preview FIFO for the game FSM.
// Random samples are filtered against the current bag; a long reject streak forces a pick.
module piece_queue #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned MAX_REJECT = 15
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [2:0] rand_in,
    input  logic       piece_req,
    output logic [2:0] piece_id,
    output logic       piece_valid,
    output logic [2:0] preview_id,
    output logic       queue_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_C  = 3'(DEPTH);
    localparam logic [3:0]    REJ_MAX  = 4'(MAX_REJECT);
    localparam logic [3:0]    REJ_LAST = 4'(MAX_REJECT - 1);

    typedef enum logic {StFill, StRun} state_e;

    state_e        state_q;
    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    mem_d [DEPTH];
    logic [2:0]    count_q, count_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_next;
    logic [6:0]    mask_q, mask_d, mask_set;
    logic [3:0]    rej_q, rej_d;

    logic       pop, gen, fallback, sample_ok, accept;
    logic [7:0] mask_ext;
    logic [2:0] free_idx, pick;
    logic [2:0] id_d, preview_d;

    always_comb begin
        pop      = piece_req && (count_q != 3'd0);
        gen      = (count_q < DEPTH_C) || pop;
        // Bit 0 stands in for rand_in=0, which is always rejected.
        mask_ext = {mask_q, 1'b1};
        sample_ok = !mask_ext[rand_in];
        fallback  = (rej_q >= REJ_LAST);

        free_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!mask_q[i]) free_idx = 3'(i);
        end

        accept = gen && (fallback || sample_ok);
        pick   = fallback ? free_idx : (rand_in - 3'd1);

        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        mask_d = mask_q;
        rej_d  = rej_q;
        mask_set = mask_q | (7'b1 << pick);

        if (gen) begin
            if (accept) rej_d = 4'd0;
            else if (rej_q < REJ_MAX) rej_d = rej_q + 4'd1;
        end

        if (accept) begin
            mem_d[wr_q] = pick;
            wr_d        = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
            // A completed bag is cleared immediately so the next accept opens a new one.
            mask_d      = (mask_set == 7'h7f) ? 7'h00 : mask_set;
        end

        if (pop) rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;

        count_d = count_q + {2'b00, accept} - {2'b00, pop};

        rd_next   = (rd_d == LAST_PTR) ? '0 : rd_d + 1'b1;
        id_d      = (count_d != 3'd0) ? mem_d[rd_d] : 3'd0;
        preview_d = (count_d >= 3'd2) ? mem_d[rd_next] : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 3'd0;
            count_q     <= 3'd0;
            rd_q        <= '0;
            wr_q        <= '0;
            mask_q      <= 7'd0;
            rej_q       <= 4'd0;
            state_q     <= StFill;
            piece_id    <= 3'd0;
            piece_valid <= 1'b0;
            preview_id  <= 3'd0;
            queue_ready <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mask_q      <= mask_d;
            rej_q       <= rej_d;
            piece_id    <= id_d;
            piece_valid <= (count_d != 3'd0);
            preview_id  <= preview_d;
            unique case (state_q)
                StFill: begin
                    if (count_d == DEPTH_C) begin
                        state_q     <= StRun;
                        queue_ready <= 1'b1;
                    end
                end
                StRun: state_q <= StRun;
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_queue.sv
// Scoreboard bench for piece_queue: a queue-based bag model predicts every cycle's outputs,
// and an independent monitor also checks that each 7 popped pieces form a full bag.
module tb_piece_queue;

    localparam int DEPTH = 3;
    localparam int MAX_REJECT = 15;

    logic       clk = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] rand_in = 3'd0;
    logic       piece_req = 1'b0;
    logic [2:0] piece_id;
    logic       piece_valid;
    logic [2:0] preview_id;
    logic       queue_ready;

    piece_queue #(.DEPTH(DEPTH), .MAX_REJECT(MAX_REJECT)) dut (
        .clk        (clk),
        .restart    (restart),
        .rand_in    (rand_in),
        .piece_req  (piece_req),
        .piece_id   (piece_id),
        .piece_valid(piece_valid),
        .preview_id (preview_id),
        .queue_ready(queue_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int valid;
        int preview;
        int ready;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    int   fifo[$];
    bit   in_bag[7];
    int   streak;
    int   m_ready;

    task automatic model_step(input bit rst, input bit req, input int rnd);
        bit do_pop, do_gen, acc;
        int p;
        int full;
        acc = 0;
        p   = 0;
        if (rst) begin
            fifo.delete();
            foreach (in_bag[i]) in_bag[i] = 0;
            streak  = 0;
            m_ready = 0;
            return;
        end
        do_pop = req && fifo.size() > 0;
        do_gen = fifo.size() < DEPTH || do_pop;
        if (do_pop) void'(fifo.pop_front());
        if (do_gen) begin
            if (streak == MAX_REJECT - 1) begin
                // This would be the MAX_REJECT-th reject in a row: take the lowest unused piece.
                for (int i = 6; i >= 0; i--) if (!in_bag[i]) p = i;
                acc = 1;
            end else if (rnd != 0 && !in_bag[rnd - 1]) begin
                p   = rnd - 1;
                acc = 1;
            end else begin
                streak++;
            end
        end
        if (acc) begin
            fifo.push_back(p);
            in_bag[p] = 1;
            full = 1;
            foreach (in_bag[i]) if (!in_bag[i]) full = 0;
            if (full != 0) foreach (in_bag[i]) in_bag[i] = 0;
            streak = 0;
        end
        if (fifo.size() == DEPTH) m_ready = 1;
    endtask

    task automatic cycle(input bit rst, input bit req, input int rnd);
        exp_t e;
        @(negedge clk);
        restart   = rst;
        piece_req = req;
        rand_in   = 3'(rnd);
        model_step(rst, req, rnd);
        e.id      = fifo.size() > 0 ? fifo[0] : 0;
        e.valid   = fifo.size() > 0 ? 1 : 0;
        e.preview = fifo.size() > 1 ? fifo[1] : 0;
        e.ready   = m_ready;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare registered outputs after every edge that has a queued expectation.
    int popped[$];
    bit prev_valid = 0;
    int prev_id = 0;
    initial begin
        exp_t e;
        int seen[7];
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("piece_id", int'(piece_id), e.id);
                check("piece_valid", int'(piece_valid), e.valid);
                check("preview_id", int'(preview_id), e.preview);
                check("queue_ready", int'(queue_ready), e.ready);
            end
            if (restart === 1'b1) begin
                popped.delete();
            end else if (piece_req === 1'b1 && prev_valid) begin
                popped.push_back(prev_id);
                if (popped.size() == 7) begin
                    foreach (seen[i]) seen[i] = 0;
                    foreach (popped[i]) if (popped[i] < 7) seen[popped[i]]++;
                    foreach (seen[i]) check($sformatf("bag_count_of_%0d", i), seen[i], 1);
                    popped.delete();
                end
            end
            prev_valid = (piece_valid === 1'b1);
            prev_id    = int'(piece_id);
        end
    end

    initial begin
        int waited;
        // Plain fill: 3,5,1 -> {2,4,0}
        cycle(1, 0, 0);
        cycle(0, 0, 3);
        cycle(0, 0, 5);
        cycle(0, 0, 1);
        check("fill_head", int'(piece_id), 2);
        check("fill_preview", int'(preview_id), 4);
        check("fill_ready", int'(queue_ready), 1);
        // Full plus pop: head leaves, 6 enters, old preview becomes head
        cycle(0, 1, 7);
        check("fullpop_head", int'(piece_id), 4);
        check("fullpop_preview", int'(preview_id), 0);
        // Duplicate sample 3 must not enqueue (2 is still in the bag)
        cycle(0, 1, 3);
        check("dup_head", int'(piece_id), 0);
        // Starvation with empty bag: 15th zero-sample cycle yields piece 0
        cycle(1, 0, 0);
        for (int i = 0; i < MAX_REJECT; i++) cycle(0, 0, 0);
        check("starve_head", int'(piece_id), 0);
        check("starve_valid", int'(piece_valid), 1);
        // Starvation with pieces 0 and 2 taken: fallback yields 1
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 3);
        for (int i = 0; i < MAX_REJECT; i++) cycle(0, 0, 0);
        check("starve2_preview", int'(preview_id), 2);
        check("starve2_ready", int'(queue_ready), 1);
        // Underflow: request with nothing queued
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        check("underflow_valid", int'(piece_valid), 0);
        check("underflow_id", int'(piece_id), 0);
        // Reset mid-operation with two queued and a pop pending
        cycle(1, 0, 0);
        cycle(0, 0, 5);
        cycle(0, 0, 6);
        cycle(1, 1, 2);
        check("midreset_valid", int'(piece_valid), 0);
        check("midreset_ready", int'(queue_ready), 0);
        cycle(0, 0, 3);
        cycle(0, 0, 5);
        cycle(0, 0, 1);
        check("refill_head", int'(piece_id), 2);
        // Random traffic, then a zero-heavy phase to exercise fallback
        for (int i = 0; i < 500; i++)
            cycle(0, ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)));
        for (int i = 0; i < 300; i++)
            cycle(0, ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 9) < 9) ? 0 : int'($urandom_range(1, 7)));
        cycle(1, 0, 0);
        for (int i = 0; i < 200; i++)
            cycle(0, ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)));
        cycle(0, 0, 0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
